// File: rtl/ovf_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : ovf_mon_pkg
// Brief  : Shared types, constants and helpers for the overflow event monitor.
// Rev    : 1.0  initial release
// ============================================================================
package ovf_mon_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'hF;

    localparam int RPT_COUNT_W = 8;
    localparam int RPT_STAMP_W = 16;

    typedef struct packed {
        logic [RPT_COUNT_W-1:0] count;
        logic [RPT_STAMP_W-1:0] stamp;
    } rpt_t;

    // Legal upstream moves: +1 (mod 16), hold, or restart from zero.
    function automatic logic seq_step_ok(input logic [3:0] prev, input logic [3:0] cur);
        return (cur == prev + 4'd1) || (cur == prev) || (cur == 4'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ovf_edge_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : ovf_edge_sat_counter
// Brief  : Overflow rise detector, saturating event counter and report period counter.
// Rev    : 1.0  initial release
// ============================================================================
module ovf_edge_sat_counter #(
    parameter int EVT_W        = 8,
    parameter int REPORT_EVERY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ovf_in,
    output logic [EVT_W-1:0] evt_count,
    output logic [EVT_W-1:0] evt_next,
    output logic             saturated,
    output logic             report_due
);

    localparam logic [EVT_W-1:0] C_EVT_ONE  = EVT_W'(1);
    localparam logic [7:0]       C_PER_LAST = 8'(REPORT_EVERY - 1);

    logic             r_ovf_q;
    logic [EVT_W-1:0] r_evt;
    logic [7:0]       r_per;
    logic             r_sat;

    logic             w_rise;
    logic             w_due;
    logic [EVT_W-1:0] w_evt_next;

    assign w_rise     = ovf_in & ~r_ovf_q;
    assign w_evt_next = (&r_evt) ? r_evt : (r_evt + C_EVT_ONE);
    assign w_due      = w_rise & (r_per == C_PER_LAST);

    // ovf_q keeps tracking through clr so a held level is never recounted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_q <= 1'b0;
            r_evt   <= '0;
            r_per   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_ovf_q <= ovf_in;
            if (clr) begin
                r_evt <= '0;
                r_per <= '0;
                r_sat <= 1'b0;
            end else if (w_rise) begin
                r_evt <= w_evt_next;
                r_per <= w_due ? 8'd0 : (r_per + 8'd1);
                if (&w_evt_next) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign evt_count  = r_evt;
    assign evt_next   = w_evt_next;
    assign saturated  = r_sat;
    assign report_due = w_due & ~clr;

endmodule
`default_nettype wire

// File: rtl/ovf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module : ovf_event_monitor
// Brief  : Counts upstream overflow events, emits periodic time-stamped reports
//          over valid/ready and flags upstream protocol/sequence violations.
// Rev    : 1.0  initial release
// ============================================================================
module ovf_event_monitor
    import ovf_mon_pkg::*;
#(
    parameter int EVT_W        = 8,
    parameter int REPORT_EVERY = 4,
    parameter int STAMP_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         cnt_in,
    input  logic               ovf_in,
    input  logic               clr,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [EVT_W-1:0]   rpt_count,
    output logic [STAMP_W-1:0] rpt_stamp,
    output logic [EVT_W-1:0]   evt_count,
    output logic               saturated,
    output logic               drop_err,
    output logic               proto_err,
    output logic               seq_err
);

    localparam logic [STAMP_W-1:0] C_STAMP_ONE = STAMP_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_drop;
    logic               w_due;
    logic [EVT_W-1:0]   w_evt_next;

    logic [STAMP_W-1:0] r_stamp;
    logic [EVT_W-1:0]   r_rpt_count;
    logic [STAMP_W-1:0] r_rpt_stamp;
    logic               r_drop;
    logic               r_proto;
    logic               r_seq;
    logic [3:0]         r_prev;
    logic               r_prev_valid;

    logic               w_proto_hit;
    logic               w_seq_hit;

    ovf_edge_sat_counter #(
        .EVT_W        (EVT_W),
        .REPORT_EVERY (REPORT_EVERY)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .ovf_in     (ovf_in),
        .evt_count  (evt_count),
        .evt_next   (w_evt_next),
        .saturated  (saturated),
        .report_due (w_due)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A due report while the previous one is still unaccepted is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_due) begin
                    w_load      = 1'b1;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (rpt_ready) begin
                    if (w_due) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_due) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
            w_load      = 1'b0;
            w_drop      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rpt_count <= '0;
            r_rpt_stamp <= '0;
        end else if (clr) begin
            r_rpt_count <= '0;
            r_rpt_stamp <= '0;
        end else if (w_load) begin
            r_rpt_count <= w_evt_next;
            r_rpt_stamp <= r_stamp;
        end
    end

    assign w_proto_hit = ovf_in & (cnt_in != CNT_MAX);
    assign w_seq_hit   = r_prev_valid & ~seq_step_ok(r_prev, cnt_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stamp      <= '0;
            r_drop       <= 1'b0;
            r_proto      <= 1'b0;
            r_seq        <= 1'b0;
            r_prev       <= 4'h0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev <= cnt_in;
            if (clr) begin
                r_stamp      <= '0;
                r_drop       <= 1'b0;
                r_proto      <= 1'b0;
                r_seq        <= 1'b0;
                r_prev_valid <= 1'b0;
            end else begin
                r_stamp      <= r_stamp + C_STAMP_ONE;
                r_prev_valid <= 1'b1;
                if (w_drop)      r_drop  <= 1'b1;
                if (w_proto_hit) r_proto <= 1'b1;
                if (w_seq_hit)   r_seq   <= 1'b1;
            end
        end
    end

    assign rpt_valid = (r_state == PEND);
    assign rpt_count = r_rpt_count;
    assign rpt_stamp = r_rpt_stamp;
    assign drop_err  = r_drop;
    assign proto_err = r_proto;
    assign seq_err   = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_ovf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_ovf_event_monitor
// Brief  : Directed bench with report scoreboard for ovf_event_monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ovf_event_monitor;
    import ovf_mon_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  a_cnt, b_cnt;
    logic        a_ovf, a_clr, a_ready, b_ovf, b_clr, b_ready;
    logic        a_valid, a_sat, a_drop, a_proto, a_seq;
    logic [7:0]  a_rcount, a_evt;
    logic [15:0] a_rstamp;
    logic        b_valid, b_sat, b_drop, b_proto, b_seq;
    logic [3:0]  b_rcount, b_evt;
    logic [15:0] b_rstamp;

    int   n_vec = 0;
    int   n_err = 0;
    int   st_a  = 0;
    int   st_b  = 0;
    rpt_t qa[$];
    rpt_t qb[$];
    rpt_t ea, eb;

    ovf_event_monitor #(.EVT_W(8), .REPORT_EVERY(4), .STAMP_W(16)) dut_a (
        .clk(clk), .reset(rst_n), .cnt_in(a_cnt), .ovf_in(a_ovf), .clr(a_clr),
        .rpt_valid(a_valid), .rpt_ready(a_ready), .rpt_count(a_rcount), .rpt_stamp(a_rstamp),
        .evt_count(a_evt), .saturated(a_sat), .drop_err(a_drop), .proto_err(a_proto), .seq_err(a_seq)
    );

    ovf_event_monitor #(.EVT_W(4), .REPORT_EVERY(1), .STAMP_W(16)) dut_b (
        .clk(clk), .reset(rst_n), .cnt_in(b_cnt), .ovf_in(b_ovf), .clr(b_clr),
        .rpt_valid(b_valid), .rpt_ready(b_ready), .rpt_count(b_rcount), .rpt_stamp(b_rstamp),
        .evt_count(b_evt), .saturated(b_sat), .drop_err(b_drop), .proto_err(b_proto), .seq_err(b_seq)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; the negedge sees what the next edge samples.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            st_a = 0;
            st_b = 0;
        end else begin
            st_a = a_clr ? 0 : st_a + 1;
            st_b = st_b + 1;
        end
    endtask

    task automatic wrap_a(input bit exp_rpt, input int exp_cnt);
        for (int i = 0; i < 16; i++) begin
            a_cnt = 4'(i);
            a_ovf = (i == 15);
            if (exp_rpt && i == 15) qa.push_back(rpt_t'{count: 8'(exp_cnt), stamp: 16'(st_a)});
            tick();
        end
        a_ovf = 1'b0;
    endtask

    task automatic wrap_b(input int exp_cnt);
        for (int i = 0; i < 16; i++) begin
            b_cnt = 4'(i);
            b_ovf = (i == 15);
            if (i == 15) qb.push_back(rpt_t'{count: 8'(exp_cnt), stamp: 16'(st_b)});
            tick();
        end
        b_ovf = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_report", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_rpt_count", int'(a_rcount), int'(ea.count));
                chk("a_rpt_stamp", int'(a_rstamp), int'(ea.stamp));
            end
        end
        if (rst_n && b_valid && b_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_report", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_rpt_count", int'(b_rcount), int'(eb.count));
                chk("b_rpt_stamp", int'(b_rstamp), int'(eb.stamp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_cnt = 4'h0; a_ovf = 1'b0; a_clr = 1'b0; a_ready = 1'b1;
        b_cnt = 4'h0; b_ovf = 1'b0; b_clr = 1'b0; b_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", int'(a_valid), 0);
        chk("rst_evt", int'(a_evt), 0);
        chk("rst_payload", int'({a_rcount, a_rstamp}), 0);
        chk("rst_flags", int'({a_sat, a_drop, a_proto, a_seq}), 0);
        rst_n = 1'b1;

        // Clean sweeps: one report after four wraps, stamp of the 4th F cycle.
        repeat (3) wrap_a(1'b0, 0);
        wrap_a(1'b1, 4);
        chk("t1_valid_rise", int'(a_valid), 1);
        tick();
        chk("t1_valid_pulse", int'(a_valid), 0);
        chk("t1_evt", int'(a_evt), 4);
        chk("t1_proto_seq", int'({a_proto, a_seq}), 0);

        // Consumer stalls across 8 wraps: first report held, second dropped.
        a_clr = 1'b1; a_cnt = 4'h0; tick(); a_clr = 1'b0;
        a_ready = 1'b0;
        repeat (3) wrap_a(1'b0, 0);
        wrap_a(1'b1, 4);
        chk("t2_valid", int'(a_valid), 1);
        repeat (3) wrap_a(1'b0, 0);
        chk("t2_hold_count", int'(a_rcount), 4);
        chk("t2_hold_stamp", int'(a_rstamp), 63);
        chk("t2_no_drop_yet", int'(a_drop), 0);
        wrap_a(1'b0, 0);
        chk("t2_drop", int'(a_drop), 1);
        chk("t2_evt", int'(a_evt), 8);
        a_ready = 1'b1;
        tick();
        chk("t2_valid_after_hs", int'(a_valid), 0);

        // Held level counts once; ovf_in away from F is a protocol error.
        a_clr = 1'b1; a_cnt = 4'h0; tick(); a_clr = 1'b0;
        repeat (5) begin a_cnt = 4'hF; a_ovf = 1'b1; tick(); end
        a_ovf = 1'b0; tick();
        chk("t3_level_once", int'(a_evt), 1);
        chk("t3_proto_clean", int'(a_proto), 0);
        a_cnt = 4'h3; a_ovf = 1'b1; tick(); a_ovf = 1'b0;
        chk("t3_proto", int'(a_proto), 1);

        // Sequence checker: hold and return-to-zero legal, 3->5 illegal.
        a_clr = 1'b1; a_cnt = 4'h0; tick(); a_clr = 1'b0;
        chk("t4_clr_flags", int'({a_proto, a_seq}), 0);
        a_cnt = 4'h7; tick(); a_cnt = 4'h7; tick(); a_cnt = 4'h0; tick(); a_cnt = 4'h1; tick();
        chk("t4_legal_seq", int'(a_seq), 0);
        a_cnt = 4'h2; tick(); a_cnt = 4'h3; tick();
        chk("t4_still_legal", int'(a_seq), 0);
        a_cnt = 4'h5; tick();
        chk("t4_seq_err", int'(a_seq), 1);

        // clr coinciding with an overflow rise while a report is pending.
        a_clr = 1'b1; a_cnt = 4'h0; tick(); a_clr = 1'b0;
        a_ready = 1'b0;
        repeat (4) wrap_a(1'b0, 0);
        chk("t5_pending", int'(a_valid), 1);
        a_cnt = 4'h0; tick();
        a_cnt = 4'hF; a_ovf = 1'b1; a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("t5_clr_evt", int'(a_evt), 0);
        chk("t5_clr_valid", int'(a_valid), 0);
        chk("t5_clr_flags", int'({a_sat, a_drop, a_proto, a_seq}), 0);
        tick();
        chk("t5_no_recount", int'(a_evt), 0);
        a_ovf = 1'b0; a_ready = 1'b1; tick();
        chk("t5_no_report", int'(a_valid), 0);

        // Asynchronous reset while a report is pending.
        a_clr = 1'b1; a_cnt = 4'h0; tick(); a_clr = 1'b0;
        a_ready = 1'b0;
        repeat (4) wrap_a(1'b0, 0);
        chk("t6_pending", int'(a_valid), 1);
        chk("t6_evt", int'(a_evt), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(a_valid), 0);
        chk("t6_async_evt", int'(a_evt), 0);
        chk("t6_async_payload", int'({a_rcount, a_rstamp}), 0);
        chk("t6_async_flags", int'({a_sat, a_drop, a_proto, a_seq}), 0);
        tick();
        rst_n = 1'b1;
        a_ready = 1'b1;
        a_cnt = 4'h0;

        // Narrow instance, report every event, saturates at 15.
        for (int k = 1; k <= 20; k++) begin
            wrap_b((k > 15) ? 15 : k);
            if (k == 14) chk("b_not_sat_at_14", int'(b_sat), 0);
            if (k == 15) begin
                chk("b_sat_at_15", int'(b_sat), 1);
                chk("b_evt_at_15", int'(b_evt), 15);
            end
        end
        tick();
        chk("b_evt_final", int'(b_evt), 15);
        chk("b_sat_final", int'(b_sat), 1);
        chk("b_no_drop", int'(b_drop), 0);

        tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
